// File: rtl/ifu_pkg.sv
// Shared fetch-path definitions: word width, reset vector, NOP encoding and buffer payload.
// Imported by ifu, ifu_buf and the downstream id/ctrl blocks.
package ifu_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] xaddr_t;

  localparam xaddr_t          RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    xaddr_t          addr;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

  function automatic xaddr_t align_word(input xaddr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_buf.sv
// In-order fetch buffer: entries are allocated at grant, filled by responses in request order,
// and popped from the head once filled. Flush discards every entry in one cycle.
module ifu_buf
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_i,
  input  xaddr_t          alloc_addr_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic            head_valid_o,
  output xaddr_t          head_addr_o,
  output logic [XLEN-1:0] head_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] unfilled_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_idx;
  logic [CNT_W-1:0] count_q, count_d, unfilled_q, unfilled_d;
  logic             fill_ok;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    filled_d   = filled_q;
    // A response with nothing awaiting data is a protocol error and is ignored.
    fill_ok    = fill_i && (unfilled_q != '0);
    // Fills arrive in order, so filled entries form a prefix starting at the head.
    fill_idx   = head_q + PTR_W'(count_q - unfilled_q);

    if (flush_i) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      filled_d   = '0;
    end else begin
      if (alloc_i) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + 1'b1;
      end
      if (fill_ok) filled_d[fill_idx] = 1'b1;
      if (pop_i) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + 1'b1;
      end
      count_d    = count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
      unfilled_d = unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_ok);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      filled_q   <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      filled_q   <= filled_d;
    end
  end

  // NOTE: payload storage is not reset; count_q and filled_q alone decide what is valid.
  always_ff @(posedge clk) begin
    if (alloc_i) mem_q[tail_q].addr <= alloc_addr_i;
    if (fill_ok) mem_q[fill_idx].data <= fill_data_i;
  end

  always_comb begin
    head_valid_o = (count_q != '0) && filled_q[head_q];
    head_addr_o  = mem_q[head_q].addr;
    head_data_o  = mem_q[head_q].data;
    count_o      = count_q;
    unfilled_o   = unfilled_q;
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, request throttling and stale-response dropping around ifu_buf.
// Delivers one instruction per cycle to decode when memory answers in a single cycle.
module ifu
  import ifu_pkg::*;
#(
  parameter xaddr_t RESET_PC  = RESET_PC_DEFAULT,
  parameter int     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            inst_valid_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  xaddr_t           pc_q, pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             run_q;
  logic [CNT_W-1:0] buf_count, buf_unfilled;
  logic             head_valid;
  xaddr_t           head_addr;
  logic [XLEN-1:0]  head_data;
  logic             grant, pop, fill;
  logic [CNT_W:0]   occupancy, outstanding;

  ifu_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_i      (grant),
    .alloc_addr_i (pc_q),
    .fill_i       (fill),
    .fill_data_i  (imem_rdata_i),
    .pop_i        (pop),
    .flush_i      (jump_en_i),
    .head_valid_o (head_valid),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .count_o      (buf_count),
    .unfilled_o   (buf_unfilled)
  );

  always_comb begin
    pop         = head_valid && !hold_i && !jump_en_i;
    // The head leaving this cycle frees its slot, which keeps a full buffer streaming.
    occupancy   = {1'b0, buf_count} + {1'b0, drop_q} - (CNT_W+1)'(pop);
    imem_req_o  = run_q && !jump_en_i && (occupancy < (CNT_W+1)'(BUF_DEPTH));
    imem_addr_o = pc_q;
    grant       = imem_req_o && imem_gnt_i;
    fill        = imem_rvalid_i && (drop_q == '0) && !jump_en_i;
    outstanding = {1'b0, drop_q} + {1'b0, buf_unfilled};

    pc_d   = pc_q;
    drop_d = drop_q;
    if (jump_en_i) begin
      pc_d   = align_word(jump_addr_i);
      // Every unanswered request turns into a drop; a response landing now retires the oldest.
      drop_d = CNT_W'(outstanding - (CNT_W+1)'(imem_rvalid_i && (outstanding != '0)));
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  // run_q keeps requests off while reset is asserted and opens them on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
      run_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      run_q  <= 1'b1;
    end
  end

  always_comb begin
    inst_valid_o = head_valid;
    inst_o       = head_valid ? head_data : INST_NOP;
    inst_addr_o  = head_valid ? head_addr : pc_q;
  end

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: a bench-side memory answers grants in order, the expected
// program-order instruction stream is queued by the driver and popped by a separate monitor.
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          DEPTH  = 2;

  logic        clk, rst_n;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        jump_en_i, hold_i;
  logic [31:0] jump_addr_i;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid_o;

  ifu #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .hold_i        (hold_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] next_exp, exp_fetch_pc, force_target;
  int          n_checks, n_errors, cyc, consumed, wrap_hits;
  int          gnt_pct, hold_pct, jump_pct, lat_min, lat_max;
  bit          spurious_en, force_jump;
  logic        last_req, last_valid;
  logic [31:0] last_inst, last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5EED_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    next_exp = {start[31:2], 2'b00};
    topup();
  endtask

  task automatic set_policy(input int g, input int h, input int j, input int lmin, input int lmax,
                            input bit sp);
    gnt_pct = g; hold_pct = h; jump_pct = j; lat_min = lmin; lat_max = lmax; spurious_en = sp;
  endtask

  // One cycle: drive at negedge+1, observe settled outputs at negedge+2.
  task automatic step();
    logic granted;
    @(negedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (pend.size() != 0 && pend[0].ready <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else if (spurious_en && pend.size() == 0 && $urandom_range(15) == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = $urandom;
    end
    imem_gnt_i  = ($urandom_range(99) < gnt_pct);
    hold_i      = ($urandom_range(99) < hold_pct);
    jump_en_i   = 1'b0;
    jump_addr_i = $urandom;
    if (force_jump) begin
      jump_en_i   = 1'b1;
      jump_addr_i = force_target;
      force_jump  = 1'b0;
    end else if ($urandom_range(99) < jump_pct) begin
      jump_en_i = 1'b1;
    end
    #1;
    last_req   = imem_req_o;
    last_valid = inst_valid_o;
    last_inst  = inst_o;
    last_addr  = imem_addr_o;
    check("imem_addr", imem_addr_o, exp_fetch_pc);
    if (!inst_valid_o) begin
      check("idle_inst", inst_o, NOP);
      check("idle_addr", inst_addr_o, exp_fetch_pc);
    end
    if (jump_en_i) check("req_in_jump", 32'(imem_req_o), 32'd0);
    granted = imem_req_o && imem_gnt_i;
    if (granted) begin
      if (imem_addr_o == 32'hFFFF_FFFC) wrap_hits++;
      pend.push_back('{addr: imem_addr_o, ready: cyc + int'($urandom_range(lat_max, lat_min))});
    end
    if (jump_en_i) begin
      exp_fetch_pc = {jump_addr_i[31:2], 2'b00};
      restart_stream(jump_addr_i);
    end else if (granted) begin
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    topup();
    cyc++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst_n         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    jump_en_i     = 1'b0;
    jump_addr_i   = '0;
    hold_i        = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, NOP);
    check("rst_inst_addr", inst_addr_o, RST_PC);
    check("rst_imem_addr", imem_addr_o, RST_PC);
    pend.delete();
    exp_fetch_pc = RST_PC;
    restart_stream(RST_PC);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every consumed instruction must be the next one in program order.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && inst_valid_o && !hold_i && !jump_en_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: consumed %h with no expected entry", inst_addr_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("inst_addr", inst_addr_o, e);
        check("inst_data", inst_o, mem_word(e));
        consumed++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    jump_en_i = 1'b0; jump_addr_i = '0; hold_i = 1'b0;
    n_checks = 0; n_errors = 0; cyc = 0; consumed = 0; wrap_hits = 0;
    force_jump = 1'b0; force_target = '0;
    exp_fetch_pc = RST_PC;
    restart_stream(RST_PC);

    // Single-cycle memory, no stalls: first request right away, then one instruction per cycle.
    pulse_reset();
    set_policy(100, 0, 0, 1, 1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) check("first_req", 32'(last_req), 32'd1);
      if (c >= 2) check("stream_valid", 32'(last_valid), 32'd1);
    end

    // Decode stall: two grants fill the buffer, then requests stop and the head holds.
    pulse_reset();
    set_policy(100, 100, 0, 1, 1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("hold_req", 32'(last_req), (c < 2) ? 32'd1 : 32'd0);
      if (c >= 2) check("hold_inst", last_inst, mem_word(RST_PC));
    end
    set_policy(100, 0, 0, 1, 1, 1'b0);
    repeat (10) step();

    // Jump with two requests outstanding: misaligned target is word aligned, stale words dropped.
    pulse_reset();
    set_policy(100, 0, 0, 3, 3, 1'b0);
    repeat (2) step();
    force_jump = 1'b1; force_target = 32'h8000_0102;
    step();
    step();
    check("jump_pc", last_addr, 32'h8000_0100);
    repeat (15) step();

    // Jump coincident with a response while a second response is still in flight.
    pulse_reset();
    set_policy(100, 0, 0, 2, 2, 1'b0);
    repeat (2) step();
    force_jump = 1'b1; force_target = 32'h0000_1000;
    step();
    repeat (15) step();

    // Fetch across the top of the address space.
    set_policy(100, 0, 0, 1, 1, 1'b0);
    force_jump = 1'b1; force_target = 32'hFFFF_FFF4;
    repeat (12) step();

    // Randomized traffic: variable grant, latency, stalls, jumps and spurious responses.
    set_policy(70, 25, 4, 1, 4, 1'b1);
    repeat (3000) step();

    // Reset with a full buffer, then refetch from the reset vector.
    set_policy(100, 100, 0, 1, 1, 1'b0);
    repeat (10) step();
    check("full_valid", 32'(last_valid), 32'd1);
    check("full_noreq", 32'(last_req), 32'd0);
    pulse_reset();
    set_policy(100, 0, 0, 1, 1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (c >= 2) check("post_rst_valid", 32'(last_valid), 32'd1);
    end

    #5;
    check("wrap_covered", 32'(wrap_hits > 0), 32'd1);
    check("progress", 32'(consumed > 300), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: fetch-buffer entries, power of two, 2..8.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 imem_req_o  output  1  fetch request valid.
REQ-006 imem_addr_o  output  32  fetch byte address, word aligned.
REQ-007 imem_gnt_i  input  1  memory accepts request this cycle (imem_req_o && imem_gnt_i).
REQ-008 imem_rvalid_i  input  1  read data valid; in order, ≥1 cycle after its grant.
REQ-009 imem_rdata_i  input  32  instruction word.
REQ-010 jump_en_i  input  1  redirect from execute (branch/jump taken).
REQ-011 jump_addr_i  input  32  redirect target.
REQ-012 hold_i  input  1  decode stall; head instruction is not consumed.
REQ-013 inst_o  output  32  instruction to decode.
REQ-014 inst_addr_o  output  32  address of inst_o.
REQ-015 inst_valid_o  output  1  inst_o/inst_addr_o hold a real fetched instruction.

Function
REQ-016 PC register holds next fetch address; imem_addr_o = PC.
REQ-017 Buffer is a circular queue of BUF_DEPTH entries {addr, data, filled}; an entry is allocated with addr=PC on each grant, filled=0.
REQ-018 imem_req_o = !jump_en_i && (allocated entries + drop_cnt) < BUF_DEPTH; never asserted during reset.
REQ-019 On grant: PC <= PC + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0); entry allocated same edge.
REQ-020 On imem_rvalid_i with drop_cnt = 0: oldest unfilled entry gets data=imem_rdata_i, filled=1.
REQ-021 On imem_rvalid_i with drop_cnt > 0: data discarded, drop_cnt decrements.
REQ-022 imem_rvalid_i with no outstanding request and drop_cnt = 0 is a protocol error; ignored, buffer unchanged.
REQ-023 inst_valid_o = head entry allocated && filled; inst_o/inst_addr_o = head data/addr.
REQ-024 When inst_valid_o = 0: inst_o = 32'h0000_0013 (NOP), inst_addr_o = PC.
REQ-025 Pop head when inst_valid_o && !hold_i && !jump_en_i; combinational output, zero-cycle latency from fill to inst_valid_o on next cycle (fill registered, visible the cycle after rvalid).
REQ-026 Allocate and pop in same cycle are both honoured; buffer full blocks only requests, never pops.
REQ-027 Fill and pop of same entry cannot coincide (fill visible only next cycle).
REQ-028 On jump_en_i: PC <= {jump_addr_i[31:2], 2'b00}; all buffer entries cleared; drop_cnt <= drop_cnt + unfilled_allocated − (imem_rvalid_i ? 1 : 0); no grant possible (req low).
REQ-029 A response arriving in the jump cycle is always discarded, whether it targets an allocated entry or a pending drop.
REQ-030 Back-to-back jumps: each recomputes drop_cnt per REQ-028; latest target wins.
REQ-031 hold_i has no effect on fetching except via buffer occupancy; jump_en_i overrides hold_i.
REQ-032 Best-case throughput: one instruction per cycle with single-cycle memory and BUF_DEPTH ≥ 2.

Reset
REQ-033 rst_n low asynchronously sets PC = RESET_PC, buffer empty, drop_cnt = 0, imem_req_o = 0, inst_valid_o = 0, inst_o = NOP, inst_addr_o = RESET_PC.
REQ-034 Responses still in flight from before reset are not tracked; memory is reset together with ifu.
REQ-035 First request asserted in the first cycle after rst_n deasserts.

Structure
REQ-036 Shared package: RESET_PC default, INST_NOP = 32'h0000_0013, XLEN-32 address width; also used by id and ctrl.
REQ-037 One sub-module ifu_buf: circular buffer with alloc, fill, pop, flush ports, occupancy and unfilled counts.
REQ-038 PC, request logic and drop counter stay in ifu.

Verification
REQ-039 Reset then gnt=1, rvalid 1 cycle after each grant, hold=0 -> inst_addr_o 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
REQ-040 hold_i=1 for 5 cycles with gnt=1 -> after 2 grants imem_req_o=0, inst_o stable at 0x8000_0000 data; release -> resumes, no loss, no duplicate.
REQ-041 Two requests outstanding, jump_en_i=1 to 0x8000_0102 -> next imem_addr_o = 0x8000_0100, both stale responses discarded, first inst_addr_o = 0x8000_0100.
REQ-042 jump_en_i coincident with imem_rvalid_i and one more outstanding -> drop_cnt = 1, both stale words never appear on inst_o.
REQ-043 PC = 32'hFFFF_FFFC granted -> next imem_addr_o = 0x0000_0000.
REQ-044 rst_n pulsed low mid-stream with full buffer -> outputs immediately at REQ-033 values, refetch from 0x8000_0000.
